macc_err_monitor: RTL and testbench

Downstream stage of the exact/approximate MACC pair. Consumes the accumulator outputs of the exact MACC and the faulty/approximate MACC each cycle, and computes windowed error metrics in hardware: count, sum of absolute error (SAE), sum of squared error (SSE) and max absolute error. This lets MAE/MSE characterisation run on-chip or in long simulations without a file-based bench. Software divides SAE/SSE by count.

---
 rtl/macc_err_monitor_if.sv | 40 ++++
 rtl/macc_err_monitor.sv | 176 +++++++++++++++++
 tb/tb_macc_err_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/macc_err_monitor_if.sv
// Control, sample and metric signals between a MACC-pair driver and macc_err_monitor.
// The bias signal exists only when MACC_ERRMON_BIAS_EN is defined.
interface macc_err_monitor_if #(
    parameter int DW    = 16,
    parameter int SAE_W = 32,
    parameter int SSE_W = 48,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             in_valid;
    logic [DW-1:0]    exact_in;
    logic [DW-1:0]    approx_in;
    logic [CNT_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [SAE_W-1:0] sae;
    logic [SSE_W-1:0] sse;
    logic [DW-1:0]    max_ae;
    logic             sat;
`ifdef MACC_ERRMON_BIAS_EN
    logic signed [SAE_W:0] bias;
`endif

    modport master (
`ifdef MACC_ERRMON_BIAS_EN
        input  bias,
`endif
        output start, in_valid, exact_in, approx_in, win_len,
        input  busy, done, count, sae, sse, max_ae, sat
    );

    modport slave (
`ifdef MACC_ERRMON_BIAS_EN
        output bias,
`endif
        input  start, in_valid, exact_in, approx_in, win_len,
        output busy, done, count, sae, sse, max_ae, sat
    );
endinterface

// File: rtl/macc_err_monitor.sv
// Windowed error metrics (count, SAE, SSE, max |err|) between exact and approximate MACC outputs.
// Define MACC_ERRMON_BIAS_EN to add the saturating signed bias sum output.
module macc_err_monitor #(
    parameter int DW    = 16,
    parameter int SAE_W = 32,
    parameter int SSE_W = 48,
    parameter int CNT_W = 16,
    parameter int SKIP  = 2
) (
    input  logic              Clk,
    input  logic              aclr_n,
    macc_err_monitor_if.slave bus
);
    localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Result MSB flags overflow; the value is clamped to all-ones in that case.
    function automatic logic [SAE_W:0] sae_add(input logic [SAE_W-1:0] acc, input logic [DW-1:0] ae);
        logic [SAE_W:0] sum;
        sum = {1'b0, acc} + (SAE_W+1)'(ae);
        if (sum[SAE_W]) sae_add = {1'b1, {SAE_W{1'b1}}};
        else            sae_add = sum;
    endfunction

    function automatic logic [SSE_W:0] sse_add(input logic [SSE_W-1:0] acc, input logic [2*DW-1:0] sq);
        logic [SSE_W:0] sum;
        sum = {1'b0, acc} + (SSE_W+1)'(sq);
        if (sum[SSE_W]) sse_add = {1'b1, {SSE_W{1'b1}}};
        else            sse_add = sum;
    endfunction

`ifdef MACC_ERRMON_BIAS_EN
    function automatic logic signed [SAE_W:0] bias_add(input logic signed [SAE_W:0] acc,
                                                       input logic signed [DW:0] d);
        logic signed [SAE_W+1:0] sum;
        sum = (SAE_W+2)'(acc) + (SAE_W+2)'(d);
        if (sum[SAE_W+1] != sum[SAE_W]) begin
            if (sum[SAE_W+1]) bias_add = {1'b1, {SAE_W{1'b0}}};
            else              bias_add = {1'b0, {SAE_W{1'b1}}};
        end else begin
            bias_add = sum[SAE_W:0];
        end
    endfunction

    logic signed [DW:0]    s1_diff_r;
    logic signed [SAE_W:0] bias_r;
    assign bus.bias = bias_r;
`endif

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  win_len_r, acc_cnt_r, count_r;
    logic [SKIP_W-1:0] skip_cnt_r;
    logic              s1_vld_r, s1_vld_nx_s, accept_s, last_s;
    logic [DW-1:0]     s1_ae_r, ae_s, max_ae_r;
    logic [2*DW-1:0]   sq_s;
    logic [SAE_W-1:0]  sae_r;
    logic [SSE_W-1:0]  sse_r;
    logic [SAE_W:0]    sae_nx_s;
    logic [SSE_W:0]    sse_nx_s;
    logic              sat_r, done_r, busy_r;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.count  = count_r;
    assign bus.sae    = sae_r;
    assign bus.sse    = sse_r;
    assign bus.max_ae = max_ae_r;
    assign bus.sat    = sat_r;

    // Absolute error of the incoming sample, unsigned and overflow free.
    always_comb begin
        if (bus.exact_in >= bus.approx_in) ae_s = bus.exact_in - bus.approx_in;
        else                               ae_s = bus.approx_in - bus.exact_in;
    end

    assign sq_s     = s1_ae_r * s1_ae_r;
    assign sae_nx_s = sae_add(sae_r, s1_ae_r);
    assign sse_nx_s = sse_add(sse_r, sq_s);
    assign last_s   = s1_vld_r && ((count_r + CNT_W'(1)) == win_len_r);

    // Next state and stage-1 acceptance; start overrides whatever state we are in.
    always_comb begin
        state_nx_s  = state_r;
        s1_vld_nx_s = 1'b0;
        accept_s    = 1'b0;
        if (bus.start) begin
            if (bus.win_len == {CNT_W{1'b0}}) state_nx_s = ST_DONE;
            else if (SKIP > 0)                state_nx_s = ST_SKIP;
            else                              state_nx_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_SKIP: begin
                    if (bus.in_valid && (skip_cnt_r == SKIP_W'(1))) state_nx_s = ST_ACCUM;
                    else                                             state_nx_s = ST_SKIP;
                end
                ST_ACCUM: begin
                    accept_s    = bus.in_valid && (acc_cnt_r < win_len_r);
                    s1_vld_nx_s = accept_s;
                    if (last_s) state_nx_s = ST_DONE;
                    else        state_nx_s = ST_ACCUM;
                end
                ST_IDLE:  state_nx_s = ST_IDLE;
                ST_DONE:  state_nx_s = ST_DONE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Window FSM, two-stage error pipeline and registered metric outputs.
    always_ff @(posedge Clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_r    <= ST_IDLE;
            win_len_r  <= {CNT_W{1'b0}};
            acc_cnt_r  <= {CNT_W{1'b0}};
            skip_cnt_r <= {SKIP_W{1'b0}};
            s1_vld_r   <= 1'b0;
            s1_ae_r    <= {DW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            sae_r      <= {SAE_W{1'b0}};
            sse_r      <= {SSE_W{1'b0}};
            max_ae_r   <= {DW{1'b0}};
            sat_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef MACC_ERRMON_BIAS_EN
            s1_diff_r  <= {(DW+1){1'b0}};
            bias_r     <= {(SAE_W+1){1'b0}};
`endif
        end else begin
            state_r  <= state_nx_s;
            s1_vld_r <= s1_vld_nx_s;
            busy_r   <= (state_nx_s == ST_SKIP) || (state_nx_s == ST_ACCUM) || s1_vld_nx_s;
            if (bus.start) begin
                win_len_r  <= bus.win_len;
                acc_cnt_r  <= {CNT_W{1'b0}};
                skip_cnt_r <= SKIP_INIT;
                count_r    <= {CNT_W{1'b0}};
                sae_r      <= {SAE_W{1'b0}};
                sse_r      <= {SSE_W{1'b0}};
                max_ae_r   <= {DW{1'b0}};
                sat_r      <= 1'b0;
                done_r     <= (bus.win_len == {CNT_W{1'b0}});
`ifdef MACC_ERRMON_BIAS_EN
                bias_r     <= {(SAE_W+1){1'b0}};
`endif
            end else begin
                if ((state_r == ST_SKIP) && bus.in_valid) skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
                if (accept_s) begin
                    s1_ae_r   <= ae_s;
                    acc_cnt_r <= acc_cnt_r + CNT_W'(1);
`ifdef MACC_ERRMON_BIAS_EN
                    s1_diff_r <= $signed({1'b0, bus.approx_in}) - $signed({1'b0, bus.exact_in});
`endif
                end
                if (s1_vld_r) begin
                    count_r <= count_r + CNT_W'(1);
                    sae_r   <= sae_nx_s[SAE_W-1:0];
                    sse_r   <= sse_nx_s[SSE_W-1:0];
                    sat_r   <= sat_r | sae_nx_s[SAE_W] | sse_nx_s[SSE_W];
                    if (s1_ae_r > max_ae_r) max_ae_r <= s1_ae_r;
`ifdef MACC_ERRMON_BIAS_EN
                    bias_r  <= bias_add(bias_r, s1_diff_r);
`endif
                end
                if (last_s) done_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_macc_err_monitor.sv
// Randomized and directed bench for macc_err_monitor: two instances (SKIP=2 and SKIP=0)
// compared every cycle against a window-level model of the error metrics.
module tb_macc_err_monitor;
    localparam int DW = 16, SAE_W = 20, SSE_W = 34, CNT_W = 16;
    localparam longint SAE_MAX  = (64'sd1 <<< SAE_W) - 64'sd1;
    localparam longint SSE_MAX  = (64'sd1 <<< SSE_W) - 64'sd1;
    localparam longint BIAS_MAX = (64'sd1 <<< SAE_W) - 64'sd1;
    localparam longint BIAS_MIN = -(64'sd1 <<< SAE_W);

    logic Clk, aclr_n;
    logic start, in_valid;
    logic [DW-1:0] exact_in, approx_in;
    logic [CNT_W-1:0] win_len;
    int chk_cnt = 0, err_cnt = 0;

    macc_err_monitor_if #(.DW(DW), .SAE_W(SAE_W), .SSE_W(SSE_W), .CNT_W(CNT_W)) if0 ();
    macc_err_monitor_if #(.DW(DW), .SAE_W(SAE_W), .SSE_W(SSE_W), .CNT_W(CNT_W)) if1 ();

    macc_err_monitor #(.DW(DW), .SAE_W(SAE_W), .SSE_W(SSE_W), .CNT_W(CNT_W), .SKIP(2))
        dut0 (.Clk(Clk), .aclr_n(aclr_n), .bus(if0));
    macc_err_monitor #(.DW(DW), .SAE_W(SAE_W), .SSE_W(SSE_W), .CNT_W(CNT_W), .SKIP(0))
        dut1 (.Clk(Clk), .aclr_n(aclr_n), .bus(if1));

    assign if0.start = start;  assign if0.in_valid = in_valid;  assign if0.win_len = win_len;
    assign if0.exact_in = exact_in;  assign if0.approx_in = approx_in;
    assign if1.start = start;  assign if1.in_valid = in_valid;  assign if1.win_len = win_len;
    assign if1.exact_in = exact_in;  assign if1.approx_in = approx_in;

    logic [63:0] o_cnt[2], o_sae[2], o_sse[2], o_max[2];
    logic o_sat[2], o_done[2], o_busy[2];
    assign o_cnt[0] = 64'(if0.count);  assign o_cnt[1] = 64'(if1.count);
    assign o_sae[0] = 64'(if0.sae);    assign o_sae[1] = 64'(if1.sae);
    assign o_sse[0] = 64'(if0.sse);    assign o_sse[1] = 64'(if1.sse);
    assign o_max[0] = 64'(if0.max_ae); assign o_max[1] = 64'(if1.max_ae);
    assign o_sat[0] = if0.sat;   assign o_sat[1] = if1.sat;
    assign o_done[0] = if0.done; assign o_done[1] = if1.done;
    assign o_busy[0] = if0.busy; assign o_busy[1] = if1.busy;
`ifdef MACC_ERRMON_BIAS_EN
    logic [63:0] o_bias[2];
    assign o_bias[0] = 64'(if0.bias); assign o_bias[1] = 64'(if1.bias);
`endif

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Window-level reference: a window accepts the valid samples numbered SKIP+1 .. SKIP+win_len
    // after start; each accepted sample lands in the metrics one clock after it was presented.
    logic   m_act[2], m_done[2], m_sat[2], m_pv[2];
    longint m_cnt[2], m_sae[2], m_sse[2], m_max[2], m_bias[2], m_pae[2], m_pd[2];
    int     m_nv[2], m_wl[2];

    task automatic model_clear(input int i);
        m_cnt[i] = 0; m_sae[i] = 0; m_sse[i] = 0; m_max[i] = 0; m_bias[i] = 0;
        m_sat[i] = 1'b0; m_pv[i] = 1'b0; m_nv[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            m_act[i] = 1'b0; m_done[i] = 1'b0; m_wl[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int skip;
        longint d;
        skip = (i == 0) ? 2 : 0;
        if (start) begin
            model_clear(i);
            m_wl[i] = int'(win_len);
            m_done[i] = (win_len == 16'd0);
            m_act[i] = (win_len != 16'd0);
        end else if (m_act[i]) begin
            if (m_pv[i]) begin
                m_cnt[i]++;
                m_sae[i] += m_pae[i];
                if (m_sae[i] > SAE_MAX) begin m_sae[i] = SAE_MAX; m_sat[i] = 1'b1; end
                m_sse[i] += m_pae[i] * m_pae[i];
                if (m_sse[i] > SSE_MAX) begin m_sse[i] = SSE_MAX; m_sat[i] = 1'b1; end
                if (m_pae[i] > m_max[i]) m_max[i] = m_pae[i];
                m_bias[i] += m_pd[i];
                if (m_bias[i] > BIAS_MAX) m_bias[i] = BIAS_MAX;
                if (m_bias[i] < BIAS_MIN) m_bias[i] = BIAS_MIN;
                if (m_cnt[i] == longint'(m_wl[i])) begin m_act[i] = 1'b0; m_done[i] = 1'b1; end
                m_pv[i] = 1'b0;
            end
            if (in_valid && (m_nv[i] < skip + m_wl[i])) begin
                m_nv[i]++;
                if (m_nv[i] > skip) begin
                    d = longint'(approx_in) - longint'(exact_in);
                    m_pd[i] = d;
                    m_pae[i] = (d < 0) ? -d : d;
                    m_pv[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("count[%0d]", i), o_cnt[i], 64'(m_cnt[i]));
            check_val($sformatf("sae[%0d]", i), o_sae[i], 64'(m_sae[i]));
            check_val($sformatf("sse[%0d]", i), o_sse[i], 64'(m_sse[i]));
            check_val($sformatf("max_ae[%0d]", i), o_max[i], 64'(m_max[i]));
            check_val($sformatf("sat[%0d]", i), {63'd0, o_sat[i]}, {63'd0, m_sat[i]});
            check_val($sformatf("done[%0d]", i), {63'd0, o_done[i]}, {63'd0, m_done[i]});
            check_val($sformatf("busy[%0d]", i), {63'd0, o_busy[i]}, {63'd0, m_act[i]});
`ifdef MACC_ERRMON_BIAS_EN
            check_val($sformatf("bias[%0d]", i), o_bias[i], 64'(m_bias[i]));
`endif
        end
    endtask

    // Drive one cycle at the falling edge, update the model at the rising edge, compare after.
    task automatic tick(input logic st, input logic v, input logic [15:0] ex, input logic [15:0] ap,
                        input logic [15:0] wl);
        start = st; in_valid = v; exact_in = ex; approx_in = ap; win_len = wl;
        @(posedge Clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge Clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic do_reset();
        aclr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        check_all();
        aclr_n = 1'b1;
    endtask

    initial begin
        logic st, v;
        logic [15:0] ex, ap, wl;
        aclr_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        exact_in = 16'd0; approx_in = 16'd0; win_len = 16'd0;
        model_reset();
        @(negedge Clk);
        check_all();
        aclr_n = 1'b1;

        // Asynchronous reset in the middle of an accumulating window
        tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd10);
        tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 16'd30, 16'd10, 16'd0);
        tick(1'b0, 1'b1, 16'd10, 16'd30, 16'd0);
        idle(1);
        check_val("t1_sae_before0", o_sae[0], 64'd40);
        check_val("t1_sae_before1", o_sae[1], 64'd40);
        do_reset();
        check_val("t1_sae_reset0", o_sae[0], 64'd0);
        check_val("t1_busy_reset0", {63'd0, o_busy[0]}, 64'd0);
        tick(1'b0, 1'b1, 16'd5, 16'd0, 16'd0);
        check_val("t1_cnt_after0", o_cnt[0], 64'd0);

        // Basic window with warm-up samples and trailing ignored samples
        tick(1'b1, 1'b1, 16'd77, 16'd0, 16'd3);
        tick(1'b0, 1'b1, 16'd100, 16'd100, 16'd0);
        tick(1'b0, 1'b1, 16'd5, 16'd9, 16'd0);
        tick(1'b0, 1'b1, 16'd10, 16'd7, 16'd0);
        tick(1'b0, 1'b1, 16'd7, 16'd10, 16'd0);
        tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        check_val("t2_done_early0", {63'd0, o_done[0]}, 64'd0);
        tick(1'b0, 1'b1, 16'd50, 16'd0, 16'd0);
        check_val("t2_done0", {63'd0, o_done[0]}, 64'd1);
        tick(1'b0, 1'b1, 16'd50, 16'd0, 16'd0);
        check_val("t2_count0", o_cnt[0], 64'd3);
        check_val("t2_sae0", o_sae[0], 64'd6);
        check_val("t2_sse0", o_sse[0], 64'd18);
        check_val("t2_max0", o_max[0], 64'd3);
        check_val("t2_sat0", {63'd0, o_sat[0]}, 64'd0);

        // Gapped valid: one sample every third cycle
        tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd4);
        for (int k = 0; k < 6; k++) begin
            case (k)
                0, 1: begin ex = 16'd0;  ap = 16'd0;  end
                2:    begin ex = 16'd11; ap = 16'd10; end
                3:    begin ex = 16'd8;  ap = 16'd10; end
                4:    begin ex = 16'd20; ap = 16'd23; end
                default: begin ex = 16'd4; ap = 16'd0; end
            endcase
            tick(1'b0, 1'b1, ex, ap, 16'd0);
            idle(2);
        end
        check_val("t3_sae0", o_sae[0], 64'd10);
        check_val("t3_sse0", o_sse[0], 64'd30);
        check_val("t3_max0", o_max[0], 64'd4);
        check_val("t3_done0", {63'd0, o_done[0]}, 64'd1);

        // Saturation of the 20-bit SAE accumulator
        tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd17);
        for (int k = 0; k < 19; k++) tick(1'b0, 1'b1, 16'hFFFF, 16'd0, 16'd0);
        idle(2);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("t4_sae[%0d]", i), o_sae[i], 64'd1048575);
            check_val($sformatf("t4_sat[%0d]", i), {63'd0, o_sat[i]}, 64'd1);
            check_val($sformatf("t4_max[%0d]", i), o_max[i], 64'd65535);
            check_val($sformatf("t4_cnt[%0d]", i), o_cnt[i], 64'd17);
        end

        // Restart mid-window, a one-sample window, then an empty window
        tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd5);
        tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 16'd0, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 16'd1, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 16'd1, 16'd0, 16'd0);
        tick(1'b1, 1'b1, 16'd9, 16'd0, 16'd1);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("t5_clr_sae[%0d]", i), o_sae[i], 64'd0);
            check_val($sformatf("t5_clr_cnt[%0d]", i), o_cnt[i], 64'd0);
        end
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 16'd3, 16'd0, 16'd0);
        idle(2);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("t5_sae[%0d]", i), o_sae[i], 64'd3);
            check_val($sformatf("t5_sse[%0d]", i), o_sse[i], 64'd9);
            check_val($sformatf("t5_cnt[%0d]", i), o_cnt[i], 64'd1);
        end
        tick(1'b1, 1'b1, 16'd7, 16'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("t5_wl0_done[%0d]", i), {63'd0, o_done[i]}, 64'd1);
            check_val($sformatf("t5_wl0_cnt[%0d]", i), o_cnt[i], 64'd0);
            check_val($sformatf("t5_wl0_busy[%0d]", i), {63'd0, o_busy[i]}, 64'd0);
        end

        // Signed bias stimulus (the unsigned metrics must match with or without the feature)
        tick(1'b1, 1'b0, 16'd0, 16'd0, 16'd2);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) tick(1'b0, 1'b1, 16'd10, 16'd12, 16'd0);
            else            tick(1'b0, 1'b1, 16'd10, 16'd7, 16'd0);
        end
        idle(2);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("t6_sae[%0d]", i), o_sae[i], 64'd5);
            check_val($sformatf("t6_sse[%0d]", i), o_sse[i], 64'd13);
            check_val($sformatf("t6_max[%0d]", i), o_max[i], 64'd3);
`ifdef MACC_ERRMON_BIAS_EN
            check_val($sformatf("t6_bias[%0d]", i), o_bias[i], 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        end

        // Randomized windows, restarts, gaps and occasional resets
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 39) == 0) || (m_done[0] && m_done[1] && ($urandom_range(0, 3) == 0));
            wl = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) begin
                ex = 16'($urandom); ap = 16'($urandom);
            end else begin
                ex = 16'($urandom_range(0, 63)); ap = 16'($urandom_range(0, 63));
            end
            v = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 599) == 0) do_reset();
            tick(st, v, ex, ap, wl);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
